// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Optional signed-overflow output is enabled by defining PCSA_OVF_EN.
module pipelined_csa_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PCSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = (BLOCK > 0) ? WIDTH / BLOCK : 1;
    localparam int BPS  = (STAGES > 0) ? NBLK / STAGES : 1;
    localparam int SW   = BPS * BLOCK;

    if (BLOCK < 1 || WIDTH % BLOCK != 0) begin : g_err_block
        $error("pipelined_csa_adder: WIDTH must be a multiple of BLOCK");
    end
    if (STAGES < 1 || NBLK % STAGES != 0) begin : g_err_stages
        $error("pipelined_csa_adder: WIDTH/BLOCK must be a multiple of STAGES");
    end

    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [STAGES-1:0] c_nxt;

    assign b_eff     = sub ? ~b : b;
    assign c0        = sub ? ~cin : cin;
    assign out_valid = v_r[STAGES-1];
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign cout      = c_r[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= '0;
            c_r <= '0;
        end else if (en) begin
            v_r[0] <= in_valid;
            for (int unsigned s = 1; s < STAGES; s++) begin
                v_r[s] <= v_r[s-1];
            end
            c_r <= c_nxt;
        end
    end

`ifdef PCSA_OVF_EN
    logic ovf_nxt;
    logic ovf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (en) begin
            ovf_r <= ovf_nxt;
        end
    end

    assign ovf = ovf_r;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        logic [SW-1:0] op_a;
        logic [SW-1:0] op_b;
        logic          cin_s;
        logic [SW-1:0] st_sum;
        logic          st_c;
        logic [SW-1:0] sd [STAGES-s];

        // Stage s consumes its operand slice s cycles after acceptance.
        if (s == 0) begin : g_in
            assign op_a  = a[SW-1:0];
            assign op_b  = b_eff[SW-1:0];
            assign cin_s = c0;
        end else begin : g_dly
            logic [SW-1:0] ad [s];
            logic [SW-1:0] bd [s];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < s; k++) begin
                        ad[k] <= '0;
                        bd[k] <= '0;
                    end
                end else if (en) begin
                    ad[0] <= a[s*SW +: SW];
                    bd[0] <= b_eff[s*SW +: SW];
                    for (int unsigned k = 1; k < s; k++) begin
                        ad[k] <= ad[k-1];
                        bd[k] <= bd[k-1];
                    end
                end
            end

            assign op_a  = ad[s-1];
            assign op_b  = bd[s-1];
            assign cin_s = c_r[s-1];
        end

        always_comb begin
            logic carry;
            carry  = cin_s;
            st_sum = '0;
            for (int unsigned k = 0; k < BPS; k++) begin
                logic [BLOCK:0] s0;
                logic [BLOCK:0] s1;
                s0 = {1'b0, op_a[k*BLOCK +: BLOCK]} + {1'b0, op_b[k*BLOCK +: BLOCK]};
                s1 = {1'b0, op_a[k*BLOCK +: BLOCK]} + {1'b0, op_b[k*BLOCK +: BLOCK]}
                     + (BLOCK+1)'(1);
                {carry, st_sum[k*BLOCK +: BLOCK]} = carry ? s1 : s0;
            end
            st_c = carry;
        end

        assign c_nxt[s] = st_c;

        // Later stages finish later, so earlier slices wait STAGES-1-s cycles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned k = 0; k < STAGES - s; k++) begin
                    sd[k] <= '0;
                end
            end else if (en) begin
                sd[0] <= st_sum;
                for (int unsigned k = 1; k < STAGES - s; k++) begin
                    sd[k] <= sd[k-1];
                end
            end
        end

        assign sum[s*SW +: SW] = sd[STAGES-1-s];

`ifdef PCSA_OVF_EN
        if (s == STAGES - 1) begin : g_ovf
            assign ovf_nxt = op_a[SW-1] ^ op_b[SW-1] ^ st_sum[SW-1] ^ st_c;
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Self-checking bench for pipelined_csa_adder: directed vectors, backpressure,
// mid-stream reset and randomized traffic against an arithmetic reference model.
module tb_pipelined_csa_adder;

    localparam int WIDTH  = 32;
    localparam int BLOCK  = 4;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PCSA_OVF_EN
    logic             ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_csa_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK), .STAGES(STAGES)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .sub(sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout)
`ifdef PCSA_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } res_t;

    // Expected result from plain integer arithmetic on the operands.
    function automatic res_t ref_model(logic [31:0] x, logic [31:0] y, logic ci, logic su);
        res_t   r;
        longint t;
        longint sx;
        longint sy;
        longint sr;
        sx = $signed(x);
        sy = $signed(y);
        if (su) begin
            t   = longint'(x) - longint'(y) - longint'(ci);
            sr  = sx - sy - longint'(ci);
            r.c = (t >= 0);
        end else begin
            t   = longint'(x) + longint'(y) + longint'(ci);
            sr  = sx + sy + longint'(ci);
            r.c = (t >= 64'sh1_0000_0000);
        end
        r.s = t[31:0];
        r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return r;
    endfunction

    bit         mv [STAGES];
    res_t       md [STAGES];
    logic [31:0] got_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < STAGES; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic tick(output bit acc);
        bit en_e;
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, mv[STAGES-1]});
        en_e = !mv[STAGES-1] || out_ready;
        chk("in_ready", {63'd0, in_ready}, {63'd0, en_e});
        if (mv[STAGES-1]) begin
            chk("sum", {32'd0, sum}, {32'd0, md[STAGES-1].s});
            chk("cout", {63'd0, cout}, {63'd0, md[STAGES-1].c});
`ifdef PCSA_OVF_EN
            chk("ovf", {63'd0, ovf}, {63'd0, md[STAGES-1].o});
`endif
            if (out_ready) got_q.push_back(sum);
        end
        acc = en_e && in_valid;
        @(posedge clk);
        if (en_e) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                md[i] = md[i-1];
            end
            mv[0] = in_valid;
            md[0] = ref_model(a, b, cin, sub);
        end
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic su, input logic [31:0] es,
                            input logic ec, input logic eo);
        bit acc;
        int n;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = su;
        out_ready = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            tick(acc);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(STAGES - 1));
        chk({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef PCSA_OVF_EN
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) $display("unexpected ovf expectation");
`endif
        tick(acc);
    endtask

    initial begin
        bit acc;
        int i;
        int n;
        int hold;
        bit started;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PCSA_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
        rst = 1'b0;

        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("stage_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_noborrow", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        directed("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: six back-to-back transactions, 3-cycle stall at first result.
        got_q.delete();
        i = 0;
        n = 0;
        hold = 0;
        started = 1'b0;
        while (got_q.size() < 6 && n < 40) begin
            in_valid  = (i < 6);
            a         = 32'(i);
            b         = 32'(i);
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = (hold == 0);
            #1;
            if (hold > 0) begin
                chk("bp_hold_sum", {32'd0, sum}, 64'd0);
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            end
            tick(acc);
            if (acc) i++;
            if (hold > 0) hold--;
            if (!started && out_valid) begin
                started = 1'b1;
                hold = 3;
            end
            n++;
        end
        chk("bp_count", 64'(got_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            chk("bp_order", {32'd0, got_q[k]}, 64'(2 * k));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 1) tick(acc);

        // Asynchronous reset with two transactions in flight.
        in_valid = 1'b1;
        a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0;
        tick(acc);
        a = 32'd30; b = 32'd40;
        tick(acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("amid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("amid_sum", {32'd0, sum}, 64'd0);
        chk("amid_cout", {63'd0, cout}, 64'd0);
        chk("amid_in_ready", {63'd0, in_ready}, 64'd1);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick(acc);
        directed("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: a = 32'hFFFF_FFFF;
                1: a = 32'h7FFF_FFFF;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            b         = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 2) tick(acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
